// File: rtl/linear_to_exponent_pkg.sv
// Shared widths and saturation constants for the linear-to-exponent converter.
package linear_to_exponent_pkg;
  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam int LZ_W  = 4;

  localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
  localparam logic [SIG_W-1:0] SIG_MAX = 4'b1111;
endpackage

// File: rtl/linear_to_exponent_if.sv
// Sample/result bus between the converter and its client.
interface linear_to_exponent_if;
  import linear_to_exponent_pkg::*;

  logic             in_valid;
  logic [IN_W-1:0]  absVal;
  logic             out_valid;
  logic [EXP_W-1:0] exponent;
  logic [SIG_W-1:0] significand;
  logic             round_bit;

  modport master (
    output in_valid, absVal,
    input  out_valid, exponent, significand, round_bit
  );

  modport slave (
    input  in_valid, absVal,
    output out_valid, exponent, significand, round_bit
  );
endinterface

// File: rtl/linear_to_exponent_lz_count.sv
// Combinational leading-zero counter over the 12-bit magnitude (0..12).
module lz_count
  import linear_to_exponent_pkg::*;
(
  input  logic [IN_W-1:0] value,
  output logic [LZ_W-1:0] count
);

  // Scan upward so the highest set bit makes the final assignment.
  always_comb begin
    count = LZ_W'(IN_W);
    for (int i = 0; i < IN_W; i++) begin
      if (value[i]) count = LZ_W'(IN_W - 1 - i);
    end
  end

endmodule

// File: rtl/linear_to_exponent.sv
// Converts a linear magnitude to exponent/significand/round with one cycle of latency.
module linear_to_exponent
  import linear_to_exponent_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  linear_to_exponent_if.slave  bus
);

  logic [LZ_W-1:0]  lz;
  logic [IN_W-1:0]  norm;
  logic [EXP_W-1:0] exp_next;
  logic [SIG_W-1:0] sig_next;
  logic             rnd_next;

  lz_count u_lz_count (
    .value (bus.absVal),
    .count (lz)
  );

  // Left-normalise so the leading one lands on bit 11 for the mid range.
  assign norm = bus.absVal << lz;

  always_comb begin
    exp_next = '0;
    sig_next = '0;
    rnd_next = 1'b0;
    if (lz == '0) begin
      exp_next = EXP_MAX;
      sig_next = SIG_MAX;
    end else if (lz <= LZ_W'(7)) begin
      exp_next = EXP_W'(4'd8 - lz);
      sig_next = norm[IN_W-1 -: SIG_W];
      rnd_next = norm[IN_W-1-SIG_W];
    end else begin
      sig_next = bus.absVal[SIG_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.exponent    <= '0;
      bus.significand <= '0;
      bus.round_bit   <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.exponent    <= exp_next;
        bus.significand <= sig_next;
        bus.round_bit   <= rnd_next;
      end
    end
  end

endmodule

// File: tb/tb_linear_to_exponent.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus literal vectors.
module tb_linear_to_exponent;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;

  linear_to_exponent_if bus();

  linear_to_exponent dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: result as {exponent, significand, round_bit} from magnitude arithmetic.
  function automatic logic [7:0] ref_conv(input int a);
    int e;
    if (a >= 2048) return {3'd7, 4'd15, 1'b0};
    if (a < 16)    return {3'd0, 4'(a), 1'b0};
    e = 1;
    while (a >= (16 << e)) e++;
    return {3'(e), 4'((a >> e) % 16), 1'((a >> (e - 1)) % 2)};
  endfunction

  logic       m_valid;
  logic [7:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_res   <= '0;
    end else begin
      m_valid <= bus.in_valid;
      if (bus.in_valid) m_res <= ref_conv(int'(bus.absVal));
    end
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got v/E/S/R=%b required %b", name, act, req);
  endtask

  function automatic logic [8:0] dut_out();
    return {bus.out_valid, bus.exponent, bus.significand, bus.round_bit};
  endfunction

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) check("cycle_model", dut_out(), {m_valid, m_res});
  end

  task automatic vec(input string name, input logic [11:0] a,
                     input logic [2:0] e, input logic [3:0] s, input logic r);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.absVal   = a;
    @(posedge clk);
    #1;
    check({name, "_dut"}, dut_out(), {1'b1, e, s, r});
    check({name, "_model"}, {1'b1, ref_conv(int'(a))}, {1'b1, e, s, r});
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.absVal   = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_state", dut_out(), 9'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vec("abs5",      12'd5,             3'b000, 4'b0101, 1'b0);
    vec("sat_ff8",   12'b111111111000,  3'b111, 4'b1111, 1'b0);
    vec("sat_800",   12'b100000000000,  3'b111, 4'b1111, 1'b0);
    vec("sat_fff",   12'b111111111111,  3'b111, 4'b1111, 1'b0);
    vec("zero",      12'b000000000000,  3'b000, 4'b0000, 1'b0);
    vec("mid_14c",   12'b000101001100,  3'b101, 4'b1010, 1'b0);
    vec("mid_07c",   12'b000001111100,  3'b011, 4'b1111, 1'b1);
    vec("edge_010",  12'd16,            3'b001, 4'b1000, 1'b0);
    vec("edge_7ff",  12'h7FF,           3'b111, 4'b1111, 1'b1);
    vec("edge_00f",  12'd15,            3'b000, 4'b1111, 1'b0);

    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.absVal   = 12'(i);
    end

    // Gap: last result (4095, saturated) must be held with out_valid low.
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.absVal   = 12'd5;
    repeat (3) begin
      @(posedge clk);
      #1 check("gap_hold", dut_out(), {1'b0, 3'd7, 4'd15, 1'b0});
    end

    vec("pre_reset", 12'b000001111100, 3'b011, 4'b1111, 1'b1);
    @(negedge clk);
    bus.absVal = 12'h123;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_out(), 9'd0);
    @(negedge clk);
    #1 check("reset_hold", dut_out(), 9'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_release_idle", dut_out(), 9'd0);
    vec("post_release", 12'd5, 3'b000, 4'b0101, 1'b0);

    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
